// File: rtl/tarot_guard_pkg.sv
// Shared types, constants and the inclusive range-hit helper for tarot_guard.
// Combinational helpers only, zero latency.
// No flow control.
package tarot_guard_pkg;

`include "tarot_guard_defs.v"

    localparam int HIT_W      = `TG_HIT_W;
    localparam int CAUSE_DMA  = `TG_CAUSE_DMA;
    localparam int CAUSE_ATOM = `TG_CAUSE_ATOM;
    localparam int CAUSE_IRQ  = `TG_CAUSE_IRQ;
    localparam int CAUSE_GIE  = `TG_CAUSE_GIE;
    localparam int CAUSE_XTRA = `TG_CAUSE_EXTRA;

    localparam logic [0:0] ST_RUN  = `TG_ST_RUN;
    localparam logic [0:0] ST_KILL = `TG_ST_KILL;

    // addr in [base, base+size] inclusive; the upper bound is widened so it cannot wrap
    function automatic logic range_hit(input logic [15:0] addr,
                                       input logic [15:0] base,
                                       input logic [15:0] size);
        logic [HIT_W-1:0] lo;
        logic [HIT_W-1:0] hi;
        logic [HIT_W-1:0] a;
        lo = HIT_W'(base);
        hi = lo + HIT_W'(size);
        a  = HIT_W'(addr);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/tarot_guard_defs.v
// Shared encodings for the tarot_guard slice: cause-bit offsets, FSM states, range-compare width.
// Pure text macros, no logic, no latency.
// No flow control; constants only.
`ifndef TAROT_GUARD_DEFS_V
`define TAROT_GUARD_DEFS_V

// Cause-vector bit offsets above the NREG per-region bits
`define TG_CAUSE_DMA   0
`define TG_CAUSE_ATOM  1
`define TG_CAUSE_IRQ   2
`define TG_CAUSE_GIE   3
`define TG_CAUSE_EXTRA 4

// FSM state encoding
`define TG_ST_RUN  1'b0
`define TG_ST_KILL 1'b1

// Range compares are done one bit wider than the address so base+size never wraps
`define TG_HIT_W 17

`endif

// File: rtl/tarot_region_check.sv
// One protected-region check: address hit plus access-mode violation.
// Purely combinational, zero latency.
// No flow control.
module tarot_region_check
    import tarot_guard_pkg::*;
(
    input  logic [15:0] addr,
    input  logic [15:0] base,
    input  logic [15:0] size,
    input  logic        mode,
    input  logic        data_en,
    input  logic        data_wr,
    input  logic        in_tcb,
    output logic        hit,
    output logic        viol
);

    assign hit = range_hit(addr, base, size);

    // mode=1 protects reads too; code running inside the trusted block is exempt
    assign viol = data_en & hit & (data_wr | mode) & ~in_tcb;

endmodule

// File: rtl/tarot_guard.sv
// Memory/TCB access guard: flags region, DMA, atomicity, IRQ and GIE violations and requests a PUC.
// reset asserts in the violating cycle (zero latency); cause/count register on the RUN->KILL edge.
// No backpressure; observes the bus every cycle and never stalls it.
module tarot_guard
    import tarot_guard_pkg::*;
#(
    parameter int                 NREG          = 4,
    parameter logic [16*NREG-1:0] REG_BASE      = {16'h0020, 16'h0130, 16'h0080, 16'hE000},
    parameter logic [16*NREG-1:0] REG_SIZE      = {16'h0006, 16'h00D0, 16'h0010, 16'h1FFF},
    parameter logic [NREG-1:0]    REG_MODE      = 4'b0000,
    parameter logic [15:0]        TCB_BASE      = 16'hFAE0,
    parameter logic [15:0]        TCB_SIZE      = 16'h03FC,
    parameter logic [15:0]        RESET_HANDLER = 16'h0000,
    parameter int                 CNT_W         = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [15:0]               pc,
    input  logic                      data_en,
    input  logic                      data_wr,
    input  logic [15:0]               data_addr,
    input  logic                      dma_en,
    input  logic [15:0]               dma_addr,
    input  logic                      irq,
    input  logic                      gie,
    output logic                      reset,
    output logic [NREG+CAUSE_XTRA-1:0] viol_cause,
    output logic [CNT_W-1:0]          viol_cnt
);

    localparam int          CW       = NREG + CAUSE_XTRA;
    localparam logic [15:0] TCB_LAST = TCB_BASE + TCB_SIZE;

    logic [15:0]     prev_pc;
    logic [0:0]      state;
    logic            in_tcb;
    logic            prev_in_tcb;
    logic [NREG-1:0] reg_viol;
    logic [NREG-1:0] dma_hit;
    logic [NREG-1:0] unused_data_hit;
    logic [NREG-1:0] unused_dma_viol;
    logic [CW-1:0]   cause;
    logic            viol_now;

    assign in_tcb      = range_hit(pc, TCB_BASE, TCB_SIZE);
    assign prev_in_tcb = range_hit(prev_pc, TCB_BASE, TCB_SIZE);

    // Each region checked independently so overlapping regions each raise their own bit
    for (genvar i = 0; i < NREG; i++) begin : g_reg
        tarot_region_check u_data_chk (
            .addr    (data_addr),
            .base    (REG_BASE[16*i +: 16]),
            .size    (REG_SIZE[16*i +: 16]),
            .mode    (REG_MODE[i]),
            .data_en (data_en),
            .data_wr (data_wr),
            .in_tcb  (in_tcb),
            .hit     (unused_data_hit[i]),
            .viol    (reg_viol[i])
        );

        // DMA is never allowed into a protected region, whatever the pc
        tarot_region_check u_dma_chk (
            .addr    (dma_addr),
            .base    (REG_BASE[16*i +: 16]),
            .size    (REG_SIZE[16*i +: 16]),
            .mode    (1'b1),
            .data_en (dma_en),
            .data_wr (1'b1),
            .in_tcb  (1'b0),
            .hit     (dma_hit[i]),
            .viol    (unused_dma_viol[i])
        );
    end

    // Combinational cause vector: all simultaneous causes are reported together
    always_comb begin
        cause                   = '0;
        cause[NREG-1:0]         = reg_viol;
        cause[NREG+CAUSE_DMA]   = dma_en & ((|dma_hit) | in_tcb);
        cause[NREG+CAUSE_ATOM]  = (~prev_in_tcb & in_tcb & (pc != TCB_BASE)) |
                                  (prev_in_tcb & ~in_tcb & (prev_pc != TCB_LAST));
        cause[NREG+CAUSE_IRQ]   = irq & in_tcb;
        cause[NREG+CAUSE_GIE]   = gie & in_tcb & (pc != TCB_BASE);
    end

    assign viol_now = |cause;
    assign reset    = (state == ST_KILL) | viol_now;

    // pc history, RUN/KILL FSM, sticky cause capture and saturating violation count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_pc    <= RESET_HANDLER;
            state      <= ST_RUN;
            viol_cause <= '0;
            viol_cnt   <= '0;
        end else begin
            prev_pc <= pc;
            case (state)
                ST_RUN: begin
                    if (viol_now) begin
                        state      <= ST_KILL;
                        viol_cause <= cause;
                        if (viol_cnt != {CNT_W{1'b1}}) begin
                            viol_cnt <= viol_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    // Only leave KILL once the core is back at the reset vector with no fresh fault
                    if ((pc == RESET_HANDLER) && !viol_now) begin
                        state <= ST_RUN;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tarot_guard.sv
module tb_tarot_guard;

    logic        clk;
    logic        rst;
    logic [15:0] pc;
    logic        data_en;
    logic        data_wr;
    logic [15:0] data_addr;
    logic        dma_en;
    logic [15:0] dma_addr;
    logic        irq;
    logic        gie;
    logic        reset;
    logic [7:0]  viol_cause;
    logic [7:0]  viol_cnt;

    typedef struct {
        int         id;
        logic       r;
        logic [7:0] c;
        logic [7:0] n;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    tarot_guard #(
        .NREG     (4),
        .REG_MODE (4'b0010),
        .CNT_W    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .data_en    (data_en),
        .data_wr    (data_wr),
        .data_addr  (data_addr),
        .dma_en     (dma_en),
        .dma_addr   (dma_addr),
        .irq        (irq),
        .gie        (gie),
        .reset      (reset),
        .viol_cause (viol_cause),
        .viol_cnt   (viol_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: each cycle that has an expectation queued, compare the DUT against it
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (reset !== e.r) begin
                    errors++;
                    $display("FAIL reset step %0d: got %b expected %b", e.id, reset, e.r);
                end
                checks++;
                if (viol_cause !== e.c) begin
                    errors++;
                    $display("FAIL viol_cause step %0d: got %02h expected %02h", e.id, viol_cause, e.c);
                end
                checks++;
                if (viol_cnt !== e.n) begin
                    errors++;
                    $display("FAIL viol_cnt step %0d: got %0d expected %0d", e.id, viol_cnt, e.n);
                end
            end
        end
    end

    // Drive one cycle of inputs just after the edge and queue what the DUT must show that cycle
    task automatic step(input logic r, input logic [15:0] p,
                        input logic de, input logic dw, input logic [15:0] da,
                        input logic me, input logic [15:0] ma,
                        input logic iq, input logic ge,
                        input logic er, input logic [7:0] ec, input logic [7:0] en);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; pc = p;
        data_en = de; data_wr = dw; data_addr = da;
        dma_en = me; dma_addr = ma;
        irq = iq; gie = ge;
        e.id = step_id; e.r = er; e.c = ec; e.n = en;
        exp_q.push_back(e);
        step_id++;
    endtask

    task automatic idle(input logic [15:0] p, input logic er,
                        input logic [7:0] ec, input logic [7:0] en);
        step(1'b0, p, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, er, ec, en);
    endtask

    task automatic wr(input logic [15:0] p, input logic [15:0] a, input logic er,
                      input logic [7:0] ec, input logic [7:0] en);
        step(1'b0, p, 1'b1, 1'b1, a, 1'b0, 16'h0, 1'b0, 1'b0, er, ec, en);
    endtask

    task automatic rd(input logic [15:0] p, input logic [15:0] a, input logic er,
                      input logic [7:0] ec, input logic [7:0] en);
        step(1'b0, p, 1'b1, 1'b0, a, 1'b0, 16'h0, 1'b0, 1'b0, er, ec, en);
    endtask

    initial begin
        int         budget;
        logic [7:0] pre_c;
        int         nexp;
        rst = 1'b1; pc = 16'h0; data_en = 1'b0; data_wr = 1'b0; data_addr = 16'h0;
        dma_en = 1'b0; dma_addr = 16'h0; irq = 1'b0; gie = 1'b0;

        // Reset state
        step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0);
        idle(16'h0000, 1'b0, 8'h00, 8'd0);

        // Write to region 0 from untrusted code, then recover at the reset vector
        wr  (16'hC000, 16'hE010, 1'b1, 8'h00, 8'd0);
        idle(16'h0000, 1'b1, 8'h01, 8'd1);
        idle(16'h0000, 1'b0, 8'h01, 8'd1);

        // Write to region 1 is allowed from inside the TCB, forbidden from outside
        idle(16'hFAE0, 1'b0, 8'h01, 8'd1);
        wr  (16'hFB00, 16'h0085, 1'b0, 8'h01, 8'd1);
        idle(16'hFEDC, 1'b0, 8'h01, 8'd1);
        wr  (16'hC000, 16'h0085, 1'b1, 8'h01, 8'd1);
        idle(16'h0000, 1'b1, 8'h02, 8'd2);

        // Atomicity: mid-TCB entry; exit from mid-TCB while already in KILL holds KILL
        idle(16'hC000, 1'b0, 8'h02, 8'd2);
        idle(16'hFB00, 1'b1, 8'h02, 8'd2);
        idle(16'h0000, 1'b1, 8'h20, 8'd3);
        idle(16'h0000, 1'b1, 8'h20, 8'd3);
        // Legal entry at base, illegal exit from the middle
        idle(16'hC000, 1'b0, 8'h20, 8'd3);
        idle(16'hFAE0, 1'b0, 8'h20, 8'd3);
        idle(16'hFB00, 1'b0, 8'h20, 8'd3);
        idle(16'hC000, 1'b1, 8'h20, 8'd3);
        idle(16'h0000, 1'b1, 8'h20, 8'd4);
        // Legal entry and legal exit through the last address
        idle(16'hFAE0, 1'b0, 8'h20, 8'd4);
        idle(16'hFEDC, 1'b0, 8'h20, 8'd4);
        idle(16'hC000, 1'b0, 8'h20, 8'd4);
        idle(16'h0000, 1'b0, 8'h20, 8'd4);

        // IRQ and GIE together inside the TCB: both bits, one count
        idle(16'hFAE0, 1'b0, 8'h20, 8'd4);
        step(1'b0, 16'hFB00, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 8'h20, 8'd4);
        idle(16'hFEDC, 1'b1, 8'hC0, 8'd5);
        idle(16'h0000, 1'b1, 8'hC0, 8'd5);
        idle(16'h0000, 1'b0, 8'hC0, 8'd5);

        // DMA into region 3
        step(1'b0, 16'hC000, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0022, 1'b0, 1'b0, 1'b1, 8'hC0, 8'd5);
        idle(16'h0000, 1'b1, 8'h10, 8'd6);
        // Read of read-protected region 1; read of write-only-protected region 0 is fine
        rd  (16'hC000, 16'h0080, 1'b1, 8'h10, 8'd6);
        idle(16'h0000, 1'b1, 8'h02, 8'd7);
        rd  (16'hC000, 16'hE010, 1'b0, 8'h02, 8'd7);
        // Inclusive upper boundary of region 3, then one past it
        wr  (16'hC000, 16'h0026, 1'b1, 8'h02, 8'd7);
        idle(16'h0000, 1'b1, 8'h08, 8'd8);
        wr  (16'hC000, 16'h0027, 1'b0, 8'h08, 8'd8);
        // Region-2 write and DMA to region 1 in the same cycle
        step(1'b0, 16'hC000, 1'b1, 1'b1, 16'h0135, 1'b1, 16'h0085, 1'b0, 1'b0, 1'b1, 8'h08, 8'd8);
        idle(16'h0000, 1'b1, 8'h14, 8'd9);
        idle(16'h0000, 1'b0, 8'h14, 8'd9);
        // DMA while the TCB runs, even to an unprotected address
        step(1'b0, 16'hFAE0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h5000, 1'b0, 1'b0, 1'b1, 8'h14, 8'd9);
        idle(16'hFEDC, 1'b1, 8'h10, 8'd10);
        idle(16'h0000, 1'b1, 8'h10, 8'd10);
        idle(16'h0000, 1'b0, 8'h10, 8'd10);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b1, 16'h5000, 1'b0, 1'b0, 1'b0, 8'h10, 8'd10);

        // 300 violate/recover rounds: count saturates at 255
        for (int k = 1; k <= 300; k++) begin
            pre_c = (k == 1) ? 8'h10 : 8'h01;
            nexp  = (9 + k > 255) ? 255 : 9 + k;
            wr  (16'hC000, 16'hE010, 1'b1, pre_c, 8'(nexp));
            nexp  = (10 + k > 255) ? 255 : 10 + k;
            idle(16'h0000, 1'b1, 8'h01, 8'(nexp));
        end
        idle(16'h0000, 1'b0, 8'h01, 8'd255);

        // rst asserted while in KILL clears everything and returns to RUN
        wr  (16'hC000, 16'hE010, 1'b1, 8'h01, 8'd255);
        step(1'b1, 16'hC000, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0);
        idle(16'hC000, 1'b0, 8'h00, 8'd0);
        idle(16'h0000, 1'b0, 8'h00, 8'd0);

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tarot_guard.md
TAROT_GUARD -- requirements
Module: tarot_guard

Interface
REQ-001 SHALL have parameter NREG, default 4, number of protected regions (1..8).
REQ-002 SHALL have parameter REG_BASE, default {16'h0020,16'h0130,16'h0080,16'hE000}, packed 16*NREG bits, region i base at bits [16i+15:16i].
REQ-003 SHALL have parameter REG_SIZE, default {16'h0006,16'h00D0,16'h0010,16'h1FFF}, packed, inclusive last offset per region.
REQ-004 SHALL have parameter REG_MODE, default 4'b0000, per region: 0 write-protect, 1 read+write-protect.
REQ-005 SHALL have parameters TCB_BASE 16'hFAE0, TCB_SIZE 16'h03FC (inclusive), RESET_HANDLER 16'h0000, CNT_W 8 (violation counter width).
REQ-006 SHALL have ports: clk in 1 clock; rst in 1 reset, asynchronous, active-high; pc in 16; data_en in 1; data_wr in 1; data_addr in 16; dma_en in 1; dma_addr in 16; irq in 1; gie in 1; reset out 1 PUC request; viol_cause out NREG+4 latched cause; viol_cnt out CNT_W violation count.

Function
REQ-007 SHALL treat an address as hitting range [B, B+S] inclusive, computed without wrap (17-bit compare).
REQ-008 SHALL define in_tcb = pc hits [TCB_BASE, TCB_BASE+TCB_SIZE]; TCB_LAST = TCB_BASE+TCB_SIZE.
REQ-009 SHALL flag cause bit i (i<NREG) when data_en & data_addr hits region i & (data_wr | REG_MODE[i]) & !in_tcb.
REQ-010 SHALL flag cause bit NREG (DMA) when dma_en & dma_addr hits any region, or when dma_en & in_tcb, regardless of pc otherwise.
REQ-011 SHALL flag cause bit NREG+1 (atomicity) when !prev_in_tcb & in_tcb & pc != TCB_BASE, or prev_in_tcb & !in_tcb & prev_pc != TCB_LAST.
REQ-012 SHALL flag cause bit NREG+2 (IRQ) when irq & in_tcb.
REQ-013 SHALL flag cause bit NREG+3 (GIE) when gie & in_tcb & pc != TCB_BASE.
REQ-014 SHALL register prev_pc every cycle; prev_in_tcb derives from prev_pc.
REQ-015 SHALL implement FSM states RUN and KILL; viol_now = OR of all cause bits.
REQ-016 RUN -> KILL when viol_now; KILL -> RUN when pc == RESET_HANDLER & !viol_now; otherwise hold.
REQ-017 SHALL drive reset = (state == KILL) | viol_now, i.e. asserted in the violating cycle, zero latency.
REQ-018 SHALL load viol_cause with the current cause vector on each RUN -> KILL transition; hold otherwise (sticky across return to RUN).
REQ-019 SHALL increment viol_cnt on each RUN -> KILL transition, saturating at all-ones; violations while in KILL neither count nor overwrite viol_cause.
REQ-020 Simultaneous causes in one cycle SHALL all be recorded in viol_cause and count once.
REQ-021 Overlapping regions SHALL each report their own bit independently.

Reset
REQ-022 On rst: state = RUN, prev_pc = RESET_HANDLER, viol_cause = 0, viol_cnt = 0; reset output = viol_now only.
REQ-023 rst asserted mid-KILL SHALL return to RUN immediately, clearing count and cause.

Structure
REQ-024 Cause-bit indices, FSM state encoding and the range-hit width rule SHALL live in a shared defines file, tarot_guard_defs.v.
REQ-025 Per-region check SHALL be sub-module tarot_region_check (addr, base, size, mode, data_en/wr, in_tcb -> hit, viol), instantiated NREG times via generate.
REQ-026 Total RTL SHALL be a single clocked process for prev_pc/FSM/cause/counter plus combinational cause logic.

Verification
REQ-027 pc=0xC000, data_en=1, data_wr=1, data_addr=0xE010 -> reset=1 same cycle, viol_cause=bit0, viol_cnt=1; pc=0x0000 next -> state RUN, reset=0.
REQ-028 pc=0xFB00 (in TCB), gie=0, write 0x0085 -> no reset; same write with pc=0xC000 -> reset, viol_cause=bit1.
REQ-029 prev_pc=0xC000, pc=0xFB00 -> atomicity bit set; prev_pc=0xC000, pc=0xFAE0 -> no violation; prev_pc=0xFB00, pc=0xC000 -> violation; prev_pc=0xFEDC, pc=0xC000 -> none.
REQ-030 pc=0xFB00 with irq=1 and gie=1 in same cycle -> viol_cause bits NREG+2 and NREG+3 both set, viol_cnt +1 only.
REQ-031 Force 300 RUN->KILL->RUN cycles with CNT_W=8 -> viol_cnt saturates at 255; rst pulse -> viol_cnt=0, viol_cause=0.
REQ-032 dma_en=1, dma_addr=0x0022, pc=0xC000 -> bit NREG set; REG_MODE=4'b0010, read of 0x0080 outside TCB -> bit1 set.
